// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM/GPIO timer family: capture FSM encoding and default counter width.
package pwm_capture_pkg;

  localparam int CNT_LENGTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a single-cycle rise/fall detector.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   level_p1;

  // Stage 0: metastability chain; Stage 1: delayed copy of the synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= '0;
      level_p1 <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], din};
      level_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise = sync_p0[SYNC_STAGES-1] & ~level_p1;
  assign fall = ~sync_p0[SYNC_STAGES-1] & level_p1;

endmodule

// File: rtl/pwm_capture.sv
// Input-capture timer: measures period and high time of a pulse train on one GPIO line, in sys_clk cycles.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_LENGTH  = CNT_LENGTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  sys_en,
  input  logic                  cap_in,
  input  logic                  ovf_clr,
  output logic [CNT_LENGTH-1:0] period,
  output logic [CNT_LENGTH-1:0] high_time,
  output logic                  cap_valid,
  output logic                  overflow,
  output logic                  busy
);

  cap_state_e            state;
  logic [CNT_LENGTH-1:0] cnt;
  logic [CNT_LENGTH-1:0] high_pend;
  logic                  rise;
  logic                  fall;
  logic                  sat;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .din  (cap_in),
    .rise (rise),
    .fall (fall)
  );

  // Counter pinned at all-ones with no edge: the input is stuck or the period is out of range.
  assign sat  = sys_en && (state == HIGH || state == LOW) && (&cnt) && !(rise || fall);
  assign busy = (state != IDLE);

  // Measurement stage: FSM, counter and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      high_pend <= '0;
      period    <= '0;
      high_time <= '0;
      cap_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if (!sys_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_LENGTH'(1);
            end
          end
          HIGH, LOW: begin
            if (rise) begin
              cnt   <= CNT_LENGTH'(1);
              state <= HIGH;
              if (state == LOW) begin
                period    <= cnt;
                high_time <= high_pend;
                cap_valid <= 1'b1;
              end
            end else if (sat) begin
              state <= ARM;
            end else begin
              cnt <= cnt + CNT_LENGTH'(1);
              if (fall && state == HIGH) begin
                high_pend <= cnt;
                state     <= LOW;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (sat) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: timestamp-based reference model plus directed literal checks.
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int SS = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_en = 1'b0;
  logic          cap_in = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          cap_valid;
  logic          overflow;
  logic          busy;

  int tests = 0;
  int fails = 0;

  pwm_capture #(
    .CNT_LENGTH (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .sys_en   (sys_en),
    .cap_in   (cap_in),
    .ovf_clr  (ovf_clr),
    .period   (period),
    .high_time(high_time),
    .cap_valid(cap_valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the input is a delay line of SS cycles; a measurement is
  // the distance between the clock edges at which successive rises (and the
  // intervening fall) take effect.
  bit dq[$];
  int m = 0;
  int mode = 0;  // 0 disabled, 1 waiting for first rise, 2 measuring
  bit have_fall = 0;
  int t_rise = 0;
  int t_fall = 0;
  int e_period = 0;
  int e_high = 0;
  bit e_valid = 0;
  bit e_ovf = 0;
  bit e_busy = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      dq = {};
      for (int i = 0; i < SS + 2; i++) dq.push_back(1'b0);
      m = 0; mode = 0; have_fall = 0; t_rise = 0; t_fall = 0;
      e_period = 0; e_high = 0; e_valid = 0; e_ovf = 0; e_busy = 0;
    end else begin
      bit r_ev, f_ev, set;
      m++;
      dq.push_back(cap_in);
      void'(dq.pop_front());
      r_ev = dq[1] & ~dq[0];
      f_ev = ~dq[1] & dq[0];
      e_valid = 0;
      set = 0;
      if (!sys_en) mode = 0;
      else if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (r_ev) begin mode = 2; t_rise = m; have_fall = 0; end
      end else begin
        if (r_ev) begin
          if (have_fall) begin
            e_valid = 1; e_period = m - t_rise; e_high = t_fall - t_rise;
          end
          t_rise = m; have_fall = 0;
        end else if (f_ev) begin
          if (!have_fall) begin have_fall = 1; t_fall = m; end
        end else if (m - t_rise == CMAX) begin
          set = 1; mode = 1;
        end
      end
      if (set) e_ovf = 1;
      else if (ovf_clr) e_ovf = 0;
      e_busy = (mode != 0);
    end
  end

  int vcnt = 0;
  int lastp = 0;
  int lasth = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cap_valid", int'(cap_valid), int'(e_valid));
    check("period", int'(period), e_period);
    check("high_time", int'(high_time), e_high);
    check("overflow", int'(overflow), int'(e_ovf));
    check("busy", int'(busy), int'(e_busy));
    if (cap_valid) begin
      vcnt++;
      lastp = int'(period);
      lasth = int'(high_time);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      cap_in = 1'b1;
      tick(hi);
      cap_in = 1'b0;
      tick(per - hi);
    end
  endtask

  int vbase;

  initial begin
    tick(3);
    check("rst_period", int'(period), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(cap_valid), 0);
    rst_n = 1'b1;
    sys_en = 1'b1;

    // Armed with a quiet input: busy, no measurements
    vbase = vcnt;
    tick(100);
    check("arm_busy", int'(busy), 1);
    check("arm_no_valid", vcnt - vbase, 0);

    // Steady 10/3, then switch to 20/15
    vbase = vcnt;
    pwm(10, 3, 5);
    tick(5);
    check("pwm10_count", vcnt - vbase, 4);
    check("pwm10_period", lastp, 10);
    check("pwm10_high", lasth, 3);
    vbase = vcnt;
    pwm(20, 15, 3);
    tick(5);
    check("pwm20_count", vcnt - vbase, 3);
    check("pwm20_period", lastp, 20);
    check("pwm20_high", lasth, 15);

    // Enable while the input is high: the first fall must not start a capture
    sys_en = 1'b0;
    tick(3);
    cap_in = 1'b1;
    tick(5);
    vbase = vcnt;
    sys_en = 1'b1;
    tick(5);
    cap_in = 1'b0;
    tick(5);
    pwm(10, 3, 3);
    tick(5);
    check("midhigh_count", vcnt - vbase, 2);
    check("midhigh_period", lastp, 10);
    check("midhigh_high", lasth, 3);

    // Minimum pulses
    vbase = vcnt;
    pwm(2, 1, 10);
    tick(5);
    check("min_count", vcnt - vbase, 10);
    check("min_period", lastp, 2);
    check("min_high", lasth, 1);

    // DC-high input saturates the counter
    vbase = vcnt;
    cap_in = 1'b1;
    tick(300);
    check("ovf_set", int'(overflow), 1);
    check("ovf_busy", int'(busy), 1);
    check("ovf_count", vcnt - vbase, 1);
    check("ovf_hold_period", int'(period), 7);
    check("ovf_hold_high", int'(high_time), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);

    // Clear coinciding with a fresh saturation: set wins
    cap_in = 1'b0;
    tick(4);
    cap_in = 1'b1;
    tick(257);
    check("ovf_pre_sat", int'(overflow), 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_set_wins", int'(overflow), 1);

    // Disable during LOW: partial measurement discarded, outputs hold
    cap_in = 1'b0;
    tick(3);
    cap_in = 1'b1;
    tick(3);
    cap_in = 1'b0;
    tick(4);
    vbase = vcnt;
    sys_en = 1'b0;
    tick(1);
    check("dis_busy", int'(busy), 0);
    tick(3);
    cap_in = 1'b1;
    tick(4);
    check("dis_no_valid", vcnt - vbase, 0);
    check("dis_hold_period", int'(period), 7);
    check("dis_hold_high", int'(high_time), 1);

    // Re-enable with a period-8 input
    cap_in = 1'b0;
    tick(3);
    sys_en = 1'b1;
    tick(2);
    vbase = vcnt;
    pwm(8, 4, 3);
    tick(5);
    check("reen_count", vcnt - vbase, 2);
    check("reen_period", lastp, 8);
    check("reen_high", lasth, 4);

    // Asynchronous reset in the middle of a count
    cap_in = 1'b1;
    tick(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_high", int'(high_time), 0);
    check("arst_overflow", int'(overflow), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(cap_valid), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
